// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM; pointers, registered status flags,
// overflow/underflow pulses and a read-data stage with latency 1 (comb RAM) or 2 (registered RAM).
module sync_fifo_ctrl #(
  parameter int ADDR_WIDTH       = 4,
  parameter int DATA_WIDTH       = 4,
  parameter int RAM_OUT_REG      = 0,
  parameter int ALMOST_FULL_NUM  = 12,
  parameter int ALMOST_EMPTY_NUM = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_NUM);
  localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_NUM);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic          wr_acc, rd_acc, full_nxt, rd_fire;

  assign wr_acc     = wr_en & ~full;
  assign rd_acc     = rd_en & ~empty;
  assign wr_ptr_nxt = wr_ptr + PW'(wr_acc);
  assign rd_ptr_nxt = rd_ptr + PW'(rd_acc);
  assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  assign full_nxt   = (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]) &&
                      (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]);

  assign ram_wr_en   = wr_acc;
  assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_data = wr_data;
  assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  // Status is computed from next-state pointers so every flag is a plain register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_count   <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      data_count   <= count_nxt;
      full         <= full_nxt;
      empty        <= (wr_ptr_nxt == rd_ptr_nxt);
      almost_full  <= (count_nxt >= AF_TH);
      almost_empty <= (count_nxt <= AE_TH);
      overflow     <= wr_en & full;
      underflow    <= rd_en & empty;
    end
  end

  // A registered RAM presents the word one cycle after the address was sampled.
  if (RAM_OUT_REG != 0) begin : g_ram_reg
    logic rd_pend;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_pend <= 1'b0;
      else     rd_pend <= rd_acc;
    end
    assign rd_fire = rd_pend;
  end else begin : g_ram_comb
    assign rd_fire = rd_acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) rd_data <= ram_rd_data;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: one instance per RAM read option, shared stimulus, queue-based
// reference model and a per-instance read-data scoreboard with latency checks.
module tb_sync_fifo_ctrl;
  localparam int AW = 4;
  localparam int DW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst, wr_en, rd_en;
  logic [DW-1:0] wr_data;
  always #5 clk = ~clk;

  logic [DW-1:0] rd_data0, rd_data1, ram_wr_data0, ram_wr_data1, ram_rd_data0, ram_rd_data1;
  logic rd_valid0, rd_valid1, full0, full1, empty0, empty1, af0, af1, ae0, ae1;
  logic ovf0, ovf1, unf0, unf1, ram_wr_en0, ram_wr_en1;
  logic [AW:0] cnt0, cnt1;
  logic [AW-1:0] ram_wr_addr0, ram_wr_addr1, ram_rd_addr0, ram_rd_addr1;

  sync_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_OUT_REG(0),
                   .ALMOST_FULL_NUM(12), .ALMOST_EMPTY_NUM(2)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .data_count(cnt0),
    .overflow(ovf0), .underflow(unf0), .ram_wr_en(ram_wr_en0), .ram_wr_addr(ram_wr_addr0),
    .ram_wr_data(ram_wr_data0), .ram_rd_addr(ram_rd_addr0), .ram_rd_data(ram_rd_data0));

  sync_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_OUT_REG(1),
                   .ALMOST_FULL_NUM(12), .ALMOST_EMPTY_NUM(2)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .data_count(cnt1),
    .overflow(ovf1), .underflow(unf1), .ram_wr_en(ram_wr_en1), .ram_wr_addr(ram_wr_addr1),
    .ram_wr_data(ram_wr_data1), .ram_rd_addr(ram_rd_addr1), .ram_rd_data(ram_rd_data1));

  // RAM models: comb read for instance 0, registered (read-first) read for instance 1
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] rd_q1 = '0;
  always @(posedge clk) begin
    if (ram_wr_en0) mem0[ram_wr_addr0] <= ram_wr_data0;
    if (ram_wr_en1) mem1[ram_wr_addr1] <= ram_wr_data1;
    rd_q1 <= mem1[ram_rd_addr1];
  end
  assign ram_rd_data0 = mem0[ram_rd_addr0];
  assign ram_rd_data1 = rd_q1;

  typedef struct { logic [DW-1:0] d; int c; } exp_t;
  exp_t q [2][$];
  logic [DW-1:0] last [2];
  logic [DW-1:0] mq [$];
  int wp = 0, rp = 0;
  int cyc = 0;
  int checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic [DW-1:0] d);
    exp_t e;
    if (rst) begin
      last[k] = '0;
    end else if (v) begin
      if (q[k].size() == 0) begin
        checks++; errors++;
        $display("FAIL dut%0d_spurious_rd_valid @cyc %0d: got rd_valid=1 data 0x%0h expected no read", k, cyc, d);
      end else begin
        e = q[k].pop_front();
        chk($sformatf("dut%0d_rd_data", k), d, e.d);
        chk($sformatf("dut%0d_rd_latency", k), cyc, e.c);
      end
      last[k] = d;
    end else begin
      chk($sformatf("dut%0d_rd_data_hold", k), d, last[k]);
    end
  endtask

  always @(negedge clk) begin
    mon(0, rd_valid0, rd_data0);
    mon(1, rd_valid1, rd_data1);
  end

  task automatic chk_flags(input string t, input logic [AW:0] dc, input logic f, input logic e,
                           input logic af, input logic ae, input logic ov, input logic un,
                           input logic eov, input logic eun);
    int n = mq.size();
    chk({t, "_data_count"}, dc, n);
    chk({t, "_full"}, f, n == DEPTH);
    chk({t, "_empty"}, e, n == 0);
    chk({t, "_almost_full"}, af, n >= 12);
    chk({t, "_almost_empty"}, ae, n <= 2);
    chk({t, "_overflow"}, ov, eov);
    chk({t, "_underflow"}, un, eun);
  endtask

  task automatic chk_reset_vals();
    chk_flags("rst0", cnt0, full0, empty0, af0, ae0, ovf0, unf0, 1'b0, 1'b0);
    chk_flags("rst1", cnt1, full1, empty1, af1, ae1, ovf1, unf1, 1'b0, 1'b0);
    chk("rst0_rd_valid", rd_valid0, 0); chk("rst1_rd_valid", rd_valid1, 0);
    chk("rst0_rd_data", rd_data0, 0);   chk("rst1_rd_data", rd_data1, 0);
    chk("rst0_rd_addr", ram_rd_addr0, 0); chk("rst0_wr_addr", ram_wr_addr0, 0);
    chk("rst1_rd_addr", ram_rd_addr1, 0); chk("rst1_wr_addr", ram_wr_addr1, 0);
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    int n = mq.size();
    logic wa, ra, eov, eun;
    exp_t e;
    wr_en = w; rd_en = r; wr_data = d;
    wa = w && (n < DEPTH);
    ra = r && (n > 0);
    eov = w && (n == DEPTH);
    eun = r && (n == 0);
    #1;
    chk("ram_wr_en0", ram_wr_en0, wa); chk("ram_wr_en1", ram_wr_en1, wa);
    chk("ram_rd_addr0", ram_rd_addr0, rp % DEPTH); chk("ram_rd_addr1", ram_rd_addr1, rp % DEPTH);
    if (wa) begin
      chk("ram_wr_addr0", ram_wr_addr0, wp % DEPTH);
      chk("ram_wr_data0", ram_wr_data0, d);
    end
    if (ra) begin
      e.d = mq[0];
      e.c = cyc + 1; q[0].push_back(e);
      e.c = cyc + 2; q[1].push_back(e);
    end
    @(posedge clk); #1;
    if (ra) begin void'(mq.pop_front()); rp = (rp + 1) % (2 * DEPTH); end
    if (wa) begin mq.push_back(d); wp = (wp + 1) % (2 * DEPTH); end
    chk_flags("dut0", cnt0, full0, empty0, af0, ae0, ovf0, unf0, eov, eun);
    chk_flags("dut1", cnt1, full1, empty1, af1, ae1, ovf1, unf1, eov, eun);
  endtask

  task automatic model_reset();
    mq.delete(); q[0].delete(); q[1].delete();
    wp = 0; rp = 0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    #1;
    chk_reset_vals();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;

    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(i));       // fill with 0..F
    step(1'b1, 1'b0, 4'h5);                                      // overflow
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, '0);           // drain + underflow
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'($urandom_range(0, 15)));
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, DW'($urandom_range(0, 15)));
    step(1'b1, 1'b0, 4'hA);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);            // back-to-back reads
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), DW'($urandom_range(0, 15)));

    while (mq.size() < DEPTH) step(1'b1, 1'b0, DW'($urandom_range(0, 15)));
    step(1'b1, 1'b1, 4'h3);                                      // full: read wins
    while (mq.size() > 0) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 4'h9);                                      // empty: write wins
    step(1'b0, 1'b1, '0);

    while (mq.size() < 5) step(1'b1, 1'b0, DW'($urandom_range(0, 15)));
    step(1'b1, 1'b1, 4'h7);                                      // read in flight
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    model_reset();
    #1;
    chk_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);            // nothing may emerge
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(i + 8));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, '0);
    repeat (4) step(1'b0, 1'b0, '0);

    chk("dut0_pending_reads", q[0].size(), 0);
    chk("dut1_pending_reads", q[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
